// File: rtl/rewire_xacc_sched.sv
// Round-robin scheduler sharing one XOR-accumulate datapath among N_REQ requesters,
// with per-requester saved contexts and a single registered response slot.
module rewire_xacc_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 1,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   ctx_clr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_data
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_t;

  slot_t                   slot_r;
  logic [IDW-1:0]          rr_ptr_r;
  logic [N_REQ-1:0][W-1:0] ctx_r;
  logic [IDW-1:0]          rsp_id_r;
  logic [W-1:0]            rsp_data_r;

  logic                    free_s;
  logic                    grant_any_s;
  logic [IDW-1:0]          grant_idx_s;
  logic [N_REQ-1:0]        grant_vec_s;
  logic                    xfer_s;

  // Requester index reached by stepping ofs places past base, wrapping at N_REQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return IDW'(sum);
  endfunction

  // Round-robin scan for the first valid requester starting at rr_ptr.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_any_s && req_valid[rr_index(rr_ptr_r, k)]) begin
        grant_any_s = 1'b1;
        grant_idx_s = rr_index(rr_ptr_r, k);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // The slot can take a new beat when empty or when its current beat leaves this cycle.
  always_comb begin
    free_s      = (slot_r == S_EMPTY) || rsp_ready;
    xfer_s      = 1'b0;
    grant_vec_s = '0;
    if (!rst && free_s && grant_any_s) begin
      xfer_s                   = 1'b1;
      grant_vec_s[grant_idx_s] = 1'b1;
    end else begin
      xfer_s      = 1'b0;
      grant_vec_s = '0;
    end
  end

  assign req_ready = grant_vec_s;
  assign rsp_valid = (slot_r == S_FULL);
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;

  // Response slot FSM, response registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r     <= S_EMPTY;
      rr_ptr_r   <= '0;
      rsp_id_r   <= '0;
      rsp_data_r <= '0;
    end else begin
      case (slot_r)
        S_EMPTY: begin
          if (xfer_s) begin
            slot_r <= S_FULL;
          end else begin
            slot_r <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (xfer_s) begin
            slot_r <= S_FULL;
          end else if (rsp_ready) begin
            slot_r <= S_EMPTY;
          end else begin
            slot_r <= S_FULL;
          end
        end
        default: begin
          slot_r <= S_EMPTY;
        end
      endcase
      if (xfer_s) begin
        rsp_data_r <= ctx_r[grant_idx_s];
        rsp_id_r   <= grant_idx_s;
        rr_ptr_r   <= (grant_idx_s == IDW'(N_REQ - 1)) ? '0 : grant_idx_s + IDW'(1);
      end else begin
        rsp_data_r <= rsp_data_r;
        rsp_id_r   <= rsp_id_r;
        rr_ptr_r   <= rr_ptr_r;
      end
    end
  end

  // Context store: a clear wins over a same-cycle accumulate into the same context.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_r <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ctx_clr[i]) begin
          ctx_r[i] <= '0;
        end else if (xfer_s && (grant_idx_s == IDW'(i))) begin
          ctx_r[i] <= ctx_r[i] ^ req_data[i*W +: W];
        end else begin
          ctx_r[i] <= ctx_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rewire_xacc_sched.sv
// Bench for rewire_xacc_sched: directed vector table followed by random traffic,
// both checked against a queue-free behavioural model of the scheduler.
module tb_rewire_xacc_sched;
  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_data;
  logic [3:0] req_ready;
  logic [3:0] ctx_clr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [0:0] rsp_data;

  rewire_xacc_sched #(.N_REQ(4), .W(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ctx_clr(ctx_clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int ctx_m[N];
  int ptr_m;
  int mv;
  int mid;
  int mdata;
  int got_ready;

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic [3:0] d;
    logic [3:0] c;
    logic       rr;
    int         er;
    int         ev;
    int         eid;
    int         ed;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input logic r, input logic rr);
    int j;
    if (r || (mv != 0 && !rr)) return -1;
    for (int k = 0; k < N; k++) begin
      j = (ptr_m + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Drive one cycle at posedge+1, check grant before the edge, check response after it.
  task automatic apply(input string tag, input logic r, input logic [3:0] v,
                       input logic [3:0] d, input logic [3:0] c, input logic rr);
    int g;
    rst = r; req_valid = v; req_data = d; ctx_clr = c; rsp_ready = rr;
    #2;
    g = model_grant(v, r, rr);
    got_ready = int'(req_ready);
    check({tag, "_ready"}, got_ready, (g < 0) ? 0 : (1 << g));
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < N; i++) ctx_m[i] = 0;
      ptr_m = 0; mv = 0; mid = 0; mdata = 0;
    end else begin
      if (g >= 0) begin
        mdata = ctx_m[g];
        mid = g;
        mv = 1;
        ctx_m[g] = ctx_m[g] ^ int'(d[g]);
        ptr_m = (g + 1) % N;
      end else if (rr) begin
        mv = 0;
      end
      for (int i = 0; i < N; i++) if (c[i]) ctx_m[i] = 0;
    end
    check({tag, "_rsp_valid"}, int'(rsp_valid), mv);
    check({tag, "_rsp_id"}, int'(rsp_id), mid);
    check({tag, "_rsp_data"}, int'(rsp_data), mdata);
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'h0; req_data = 4'h0; ctx_clr = 4'h0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) ctx_m[i] = 0;
    ptr_m = 0; mv = 0; mid = 0; mdata = 0; got_ready = 0;

    // reset held with all requesters valid
    tbl.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 1, 1, 0, 0});
    // single stream on requester 1, data 1,1,0,1
    tbl.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 2, 1, 1, 0});
    tbl.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 2, 1, 1, 1});
    tbl.push_back('{1'b0, 4'h2, 4'h0, 4'h0, 1'b1, 2, 1, 1, 0});
    tbl.push_back('{1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 2, 1, 1, 0});
    // move pointer to 0 via requester 3, then round robin with wrap
    tbl.push_back('{1'b0, 4'h8, 4'h0, 4'h0, 1'b1, 8, 1, 3, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 1, 1, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 2, 1, 1, 1});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 4, 1, 2, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 8, 1, 3, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 1, 1, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 2, 1, 1, 1});
    // backpressure for three cycles, then release
    tbl.push_back('{1'b0, 4'h4, 4'h4, 4'h0, 1'b1, 4, 1, 2, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 0, 1, 2, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 0, 1, 2, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 0, 1, 2, 0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 8, 1, 3, 0});
    // clear collides with a requester 2 beat (ctx[2] is 1 here)
    tbl.push_back('{1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 4, 1, 2, 1});
    tbl.push_back('{1'b0, 4'h4, 4'h0, 4'h0, 1'b1, 4, 1, 2, 0});
    // clearing a non-granted requester leaves the grant alone
    tbl.push_back('{1'b0, 4'h2, 4'h0, 4'h1, 1'b1, 2, 1, 1, 1});
    // reset while a response is stalled
    tbl.push_back('{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 0, 1, 1, 1});
    tbl.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 4'h2, 4'h0, 4'h0, 1'b1, 2, 1, 1, 0});

    @(posedge clk);
    #1;
    for (int n = 0; n < tbl.size(); n++) begin
      apply($sformatf("vec%0d", n), tbl[n].r, tbl[n].v, tbl[n].d, tbl[n].c, tbl[n].rr);
      check($sformatf("vec%0d_tbl_ready", n), got_ready, tbl[n].er);
      check($sformatf("vec%0d_tbl_valid", n), int'(rsp_valid), tbl[n].ev);
      check($sformatf("vec%0d_tbl_id", n), int'(rsp_id), tbl[n].eid);
      check($sformatf("vec%0d_tbl_data", n), int'(rsp_data), tbl[n].ed);
    end

    for (int n = 0; n < 600; n++) begin
      apply($sformatf("rnd%0d", n),
            ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
